// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that shares one 4:1 data path among four valid/ready
// requesters, holding each grant for at most MAX_BURST beats.
//
// state | meaning
// IDLE  | no owner; pick the next requester starting at ptr
// GRANT | sel owns the output until MAX_BURST beats or it drops valid
module mux4_rr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [3:0]            io_req_valid,
    input  logic [DATA_WIDTH-1:0] io_req_bits_0,
    input  logic [DATA_WIDTH-1:0] io_req_bits_1,
    input  logic [DATA_WIDTH-1:0] io_req_bits_2,
    input  logic [DATA_WIDTH-1:0] io_req_bits_3,
    output logic [3:0]            io_req_ready,
    output logic                  io_out_valid,
    output logic [DATA_WIDTH-1:0] io_out_bits,
    input  logic                  io_out_ready,
    output logic [1:0]            io_selector,
    output logic                  io_busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state;
    logic [1:0]       sel;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       next_sel;
    logic             owner_valid;
    logic             beat;

    // Scan downward so the closest set bit after ptr is the last one written.
    always_comb begin
        next_sel = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (io_req_valid[ptr + 2'(k)]) begin
                next_sel = ptr + 2'(k);
            end
        end
    end

    always_comb begin
        case (sel)
            2'd0:    io_out_bits = io_req_bits_0;
            2'd1:    io_out_bits = io_req_bits_1;
            2'd2:    io_out_bits = io_req_bits_2;
            default: io_out_bits = io_req_bits_3;
        endcase
    end

    assign owner_valid  = io_req_valid[sel];
    assign io_out_valid = (state == GRANT) && owner_valid;
    assign beat         = io_out_valid && io_out_ready;
    assign io_selector  = sel;
    assign io_busy      = (state == GRANT);

    always_comb begin
        io_req_ready = 4'b0000;
        if (state == GRANT) begin
            io_req_ready[sel] = io_out_ready;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            sel   <= 2'd0;
            ptr   <= 2'd0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|io_req_valid) begin
                        sel   <= next_sel;
                        cnt   <= '0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (!owner_valid || (beat && cnt == LAST_BEAT)) begin
                        state <= IDLE;
                        ptr   <= sel + 2'd1;
                        cnt   <= '0;
                    end else if (beat) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: stimulus queues expected beats, a
// negedge monitor pops and compares every accepted output beat.
module tb_mux4_rr_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] io_req_valid;
    logic [7:0] io_req_bits_0, io_req_bits_1, io_req_bits_2, io_req_bits_3;
    logic [3:0] io_req_ready;
    logic       io_out_valid;
    logic [7:0] io_out_bits;
    logic       io_out_ready;
    logic [1:0] io_selector;
    logic       io_busy;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] sel;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int    n_vec = 0;
    int    n_err = 0;
    int    pat[7] = '{1, 0, 0, 1, 1, 0, 1};

    mux4_rr_arbiter #(.DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_req_valid (io_req_valid),
        .io_req_bits_0(io_req_bits_0),
        .io_req_bits_1(io_req_bits_1),
        .io_req_bits_2(io_req_bits_2),
        .io_req_bits_3(io_req_bits_3),
        .io_req_ready (io_req_ready),
        .io_out_valid (io_out_valid),
        .io_out_bits  (io_out_bits),
        .io_out_ready (io_out_ready),
        .io_selector  (io_selector),
        .io_busy      (io_busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic [1:0] s);
        beat_t b;
        b.data = d;
        b.sel  = s;
        exp_q.push_back(b);
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        io_req_valid = 4'b0000;
        io_out_ready = 1'b0;
        cyc(2);
        reset = 1'b1;
    endtask

    always @(negedge clock) begin
        if (reset === 1'b1 && io_out_valid === 1'b1 && io_out_ready === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_beat: got data 0x%0h sel %0d, expected no beat",
                         io_out_bits, io_selector);
            end else begin
                mon_e = exp_q.pop_front();
                if (io_out_bits !== mon_e.data || io_selector !== mon_e.sel ||
                    io_req_ready !== (4'b0001 << mon_e.sel)) begin
                    n_err++;
                    $display("FAIL beat: got data 0x%0h sel %0d ready %b, expected data 0x%0h sel %0d ready %b",
                             io_out_bits, io_selector, io_req_ready,
                             mon_e.data, mon_e.sel, 4'b0001 << mon_e.sel);
                end
            end
        end
    end

    initial begin
        reset         = 1'b0;
        io_req_valid  = 4'b0000;
        io_out_ready  = 1'b0;
        io_req_bits_0 = 8'h11;
        io_req_bits_1 = 8'h22;
        io_req_bits_2 = 8'h33;
        io_req_bits_3 = 8'h44;

        // reset and idle
        cyc(2);
        chk("rst_outs", 32'({io_out_valid, io_req_ready, io_selector, io_busy}), 32'd0);
        chk("rst_bits", 32'(io_out_bits), 32'h11);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("idle_outs", 32'({io_out_valid, io_req_ready, io_selector, io_busy}), 32'd0);
        end

        // single requester
        do_reset();
        io_req_bits_2 = 8'hA5;
        io_req_valid  = 4'b0100;
        io_out_ready  = 1'b1;
        repeat (4) push(8'hA5, 2'd2);
        cyc(1);
        chk("t2_grant_busy", 32'(io_busy), 32'd1);
        chk("t2_grant_sel", 32'(io_selector), 32'd2);
        chk("t2_grant_ready", 32'(io_req_ready), 32'b0100);
        cyc(4);
        chk("t2_release_busy", 32'(io_busy), 32'd0);
        chk("t2_q_empty", 32'(exp_q.size()), 32'd0);
        cyc(1);
        chk("t2_regrant_busy", 32'(io_busy), 32'd1);
        chk("t2_regrant_sel", 32'(io_selector), 32'd2);
        io_req_valid = 4'b0000;
        cyc(1);
        chk("t2_drop_idle", 32'(io_busy), 32'd0);

        // full contention
        do_reset();
        io_req_bits_0 = 8'h30;
        io_req_bits_1 = 8'h31;
        io_req_bits_2 = 8'h32;
        io_req_bits_3 = 8'h33;
        io_req_valid  = 4'b1111;
        io_out_ready  = 1'b1;
        for (int g = 0; g < 5; g++) begin
            repeat (4) push(8'(8'h30 + (g % 4)), 2'(g % 4));
        end
        cyc(1);
        chk("t3_first_sel", 32'(io_selector), 32'd0);
        chk("t3_first_busy", 32'(io_busy), 32'd1);
        cyc(5);
        chk("t3_second_sel", 32'(io_selector), 32'd1);
        chk("t3_second_busy", 32'(io_busy), 32'd1);
        cyc(18);
        chk("t3_q_at_24", 32'(exp_q.size()), 32'd1);
        cyc(1);
        chk("t3_q_at_25", 32'(exp_q.size()), 32'd0);
        chk("t3_idle_at_25", 32'(io_busy), 32'd0);
        io_req_valid = 4'b0000;

        // backpressure
        do_reset();
        io_req_valid = 4'b0010;
        push(8'h50, 2'd1);
        push(8'h53, 2'd1);
        push(8'h54, 2'd1);
        push(8'h56, 2'd1);
        cyc(1);
        for (int i = 0; i < 7; i++) begin
            io_out_ready  = (pat[i] != 0);
            io_req_bits_1 = 8'(8'h50 + i);
            #1;
            chk("t4_ready_mirror", 32'(io_req_ready), (pat[i] != 0) ? 32'b0010 : 32'd0);
            chk("t4_busy", 32'(io_busy), 32'd1);
            cyc(1);
        end
        chk("t4_release", 32'(io_busy), 32'd0);
        chk("t4_q_empty", 32'(exp_q.size()), 32'd0);
        io_req_valid = 4'b0000;
        io_out_ready = 1'b0;

        // early drop
        do_reset();
        io_req_valid  = 4'b1000;
        io_req_bits_3 = 8'hC1;
        io_req_bits_1 = 8'hEE;
        io_out_ready  = 1'b1;
        push(8'hC1, 2'd3);
        push(8'hC2, 2'd3);
        for (int i = 0; i < 4; i++) push(8'(8'hD0 + i), 2'd0);
        cyc(1);
        chk("t5_grant3", 32'(io_selector), 32'd3);
        cyc(1);
        io_req_bits_3 = 8'hC2;
        cyc(1);
        io_req_valid = 4'b0011;
        cyc(1);
        chk("t5_drop_idle", 32'(io_busy), 32'd0);
        chk("t5_drop_sel", 32'(io_selector), 32'd3);
        cyc(1);
        chk("t5_grant0_busy", 32'(io_busy), 32'd1);
        chk("t5_grant0_sel", 32'(io_selector), 32'd0);
        for (int i = 0; i < 4; i++) begin
            io_req_bits_0 = 8'(8'hD0 + i);
            cyc(1);
        end
        chk("t5_release", 32'(io_busy), 32'd0);
        chk("t5_q_empty", 32'(exp_q.size()), 32'd0);
        io_req_valid = 4'b0000;

        // async reset mid-burst
        do_reset();
        io_req_valid  = 4'b0110;
        io_req_bits_1 = 8'h71;
        io_req_bits_2 = 8'hE1;
        io_out_ready  = 1'b1;
        repeat (4) push(8'h71, 2'd1);
        push(8'hE1, 2'd2);
        cyc(1);
        chk("t6_grant1", 32'(io_selector), 32'd1);
        cyc(5);
        chk("t6_grant2_sel", 32'(io_selector), 32'd2);
        chk("t6_grant2_busy", 32'(io_busy), 32'd1);
        cyc(1);
        io_req_bits_2 = 8'hE2;
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(io_out_valid), 32'd0);
        chk("t6_rst_ready", 32'(io_req_ready), 32'd0);
        chk("t6_rst_busy", 32'(io_busy), 32'd0);
        chk("t6_rst_sel", 32'(io_selector), 32'd0);
        io_req_valid  = 4'b0101;
        io_req_bits_0 = 8'h0F;
        cyc(2);
        reset = 1'b1;
        chk("t6_post_idle", 32'(io_busy), 32'd0);
        cyc(1);
        chk("t6_regrant_busy", 32'(io_busy), 32'd1);
        chk("t6_regrant_sel", 32'(io_selector), 32'd0);
        push(8'h0F, 2'd0);
        cyc(1);
        io_req_valid = 4'b0000;
        cyc(2);
        chk("t6_final_idle", 32'(io_busy), 32'd0);
        chk("t6_q_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
